// File: rtl/imm_extend_pipe.sv
// Immediate-extension unit for the decode stage.
// Extends an IN_W-bit immediate to OUT_W bits in one of four modes and
// registers the result behind a valid/ready handshake. A two-entry skid
// buffer lets the unit accept one immediate per cycle under back-pressure.
// in_ready is derived only from registered state and rst, so it has no
// combinational path from out_ready.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_EMPTY | neither main nor skid holds data; in_ready=1, out_valid=0
// ST_ONE   | main holds the oldest entry; in_ready=1, out_valid=1
// ST_TWO   | main and skid both hold data; in_ready=0, out_valid=1
module imm_extend_pipe #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       out_mode
);

    localparam int EXT_W = OUT_W - IN_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_SEXT   = 2'b00,
        MODE_ZEXT   = 2'b01,
        MODE_UPPER  = 2'b10,
        MODE_BRANCH = 2'b11
    } mode_t;

    state_t state;
    state_t state_nxt;

    logic [OUT_W-1:0] main_data;
    logic [1:0]       main_mode;
    logic [OUT_W-1:0] skid_data;
    logic [1:0]       skid_mode;

    logic [OUT_W-1:0] sext_val;
    logic [OUT_W-1:0] zext_val;
    logic [OUT_W-1:0] upper_val;
    logic [OUT_W-1:0] branch_val;
    logic [OUT_W-1:0] ext_data;

    logic             in_xfer;
    logic             out_xfer;
    logic             load_main;
    logic             load_skid;
    logic             main_from_skid;
    logic [OUT_W-1:0] main_src_data;
    logic [1:0]       main_src_mode;

    // Handshake outputs come straight from the state register (and rst),
    // never from out_ready.
    assign out_valid = (state != ST_EMPTY);
    assign in_ready  = !rst && (state != ST_TWO);
    assign out_data  = main_data;
    assign out_mode  = main_mode;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Compute all four extension forms of the incoming immediate and select one by mode.
    always_comb begin
        sext_val   = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
        zext_val   = {{EXT_W{1'b0}}, in_imm};
        upper_val  = {in_imm, {EXT_W{1'b0}}};
        // Branch offsets are sign-extended first, then scaled; bits shifted
        // past the MSB are simply lost.
        branch_val = sext_val << BR_SHIFT;
        ext_data   = sext_val;
        case (mode_t'(in_mode))
            MODE_SEXT:   ext_data = sext_val;
            MODE_ZEXT:   ext_data = zext_val;
            MODE_UPPER:  ext_data = upper_val;
            MODE_BRANCH: ext_data = branch_val;
            default:     ext_data = sext_val;
        endcase
    end

    // Next-state and register-load decisions for the two-entry buffer.
    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_nxt = ST_ONE;
                    load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    // Drain and refill in the same cycle: main takes the new entry.
                    state_nxt = ST_ONE;
                    load_main = 1'b1;
                end else if (in_xfer) begin
                    state_nxt = ST_TWO;
                    load_skid = 1'b1;
                end else if (out_xfer) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only the drain side can move.
                if (out_xfer) begin
                    state_nxt      = ST_ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Main register is fed either by the skid entry (draining TWO) or by the new immediate.
    always_comb begin
        main_src_data = ext_data;
        main_src_mode = in_mode;
        if (main_from_skid) begin
            main_src_data = skid_data;
            main_src_mode = skid_mode;
        end
    end

    // State and buffer registers; reset wins over any transfer in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            main_data <= '0;
            main_mode <= '0;
            skid_data <= '0;
            skid_mode <= '0;
        end else begin
            state <= state_nxt;
            if (load_main) begin
                main_data <= main_src_data;
                main_mode <= main_src_mode;
            end
            if (load_skid) begin
                skid_data <= ext_data;
                skid_mode <= in_mode;
            end
        end
    end

endmodule
